mdu_unit: RTL and testbench

Iterative multiply/divide unit for the multi-cycle CPU. It sits directly downstream of the controller: it consumes the `div_start`, `divu_start`, `mul_start` and `mulu_start` strobes plus the Rs/Rt operand values, and returns `busy`. The controller holds its final state while `busy` is high. The HI/LO write muxes then capture `hi_out`/`lo_out`. One shared radix-2 datapath serves all four operations and produces a 64-bit result in 34 cycles.

---
 rtl/mdu_pkg.sv | 7 +
 rtl/mdu_if.sv | 10 +
 rtl/mdu_iter_step.sv | 22 ++
 rtl/mdu_unit.sv | 80 ++++++++
 tb/tb_mdu_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_MUL, OP_MULU} mdu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_t;
  localparam int MDU_ITERS = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITERS);
endpackage

// File: rtl/mdu_if.sv
// mdu_if: controller <-> mdu bundle; master drives operands/start strobes, slave returns busy/done/results
interface mdu_if #(parameter int WIDTH = 32) ();
  logic [WIDTH-1:0] a, b, hi_out, lo_out;
  logic div_start, divu_start, mul_start, mulu_start;
  logic busy, done, div_zero;
  modport master (output a, b, div_start, divu_start, mul_start, mulu_start,
                  input busy, done, hi_out, lo_out, div_zero);
  modport slave (input a, b, div_start, divu_start, mul_start, mulu_start,
                 output busy, done, hi_out, lo_out, div_zero);
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one radix-2 iteration; is_div selects restoring divide or shift-add multiply
// ports: rem (upper acc / remainder, WIDTH+1), low (multiplier / dividend word), opd (multiplicand / divisor)
//        rem_nx, mul_lo_nx (next low word for multiply), q_bit (quotient bit for divide)
module mdu_iter_step #(parameter int WIDTH = 32) (
  input  logic             is_div,
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH:0]   rem_nx,
  output logic [WIDTH-1:0] mul_lo_nx,
  output logic             q_bit
);
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH+1:0] diff;
  assign sum = rem + {1'b0, opd & {WIDTH{low[0]}}};
  assign sh = {rem[WIDTH-1:0], low[WIDTH-1]};
  // borrow out of the trial subtract means the divisor did not fit
  assign diff = {1'b0, sh} - {2'b0, opd};
  assign q_bit = is_div & ~diff[WIDTH+1];
  assign rem_nx = is_div ? (q_bit ? diff[WIDTH:0] : sh) : {1'b0, sum[WIDTH:1]};
  assign mul_lo_nx = {sum[0], low[WIDTH-1:1]};
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative signed/unsigned multiply and divide, 34-cycle busy window
// ports: clk, rst_n (async active-low), io (mdu_if.slave: a, b, four start strobes in;
//        busy, done, hi_out, lo_out, div_zero out)
module mdu_unit import mdu_pkg::*; #(parameter int WIDTH = 32) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave io
);
  mdu_state_t state, state_nx;
  mdu_op_t op, op_sel;
  logic [MDU_CNT_W-1:0] cnt;
  logic req, req_q, accept, is_div, sel_div, sel_signed, q_sign, r_sign, q_bit, dz;
  logic [WIDTH:0] rem, rem_nx;
  logic [WIDTH-1:0] low, mul_lo_nx, opd, a_raw, a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;
  assign req = io.div_start | io.divu_start | io.mul_start | io.mulu_start;
  assign accept = req & ~req_q & (state == IDLE);
  assign io.busy = accept | (state != IDLE);
  assign op_sel = io.div_start ? OP_DIV : io.divu_start ? OP_DIVU : io.mul_start ? OP_MUL : OP_MULU;
  assign sel_div = io.div_start | io.divu_start;
  assign sel_signed = io.div_start | (~io.divu_start & io.mul_start);
  assign a_abs = (sel_signed & io.a[WIDTH-1]) ? -io.a : io.a;
  assign b_abs = (sel_signed & io.b[WIDTH-1]) ? -io.b : io.b;
  assign is_div = (op == OP_DIV) | (op == OP_DIVU);
  assign prod = {rem[WIDTH-1:0], low};
  assign prod_fix = q_sign ? -prod : prod;
  assign quo_fix = q_sign ? -low : low;
  assign rem_fix = r_sign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  assign dz = is_div & (opd == '0);
  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div(is_div), .rem(rem), .low(low), .opd(opd),
    .rem_nx(rem_nx), .mul_lo_nx(mul_lo_nx), .q_bit(q_bit)
  );
  always_comb
    state_nx = accept ? CALC
             : (state == CALC && cnt == MDU_CNT_W'(MDU_ITERS - 1)) ? FIX
             : (state == FIX) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= OP_DIV;
      cnt <= '0;
      req_q <= 1'b0;
      rem <= '0;
      low <= '0;
      opd <= '0;
      a_raw <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      io.done <= 1'b0;
      io.hi_out <= '0;
      io.lo_out <= '0;
      io.div_zero <= 1'b0;
    end else begin
      req_q <= req;
      io.done <= state == FIX;
      if (accept) begin
        op <= op_sel;
        cnt <= '0;
        rem <= '0;
        low <= sel_div ? a_abs : b_abs;
        opd <= sel_div ? b_abs : a_abs;
        a_raw <= io.a;
        q_sign <= sel_signed & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
        r_sign <= sel_signed & io.a[WIDTH-1];
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nx;
        low <= is_div ? {low[WIDTH-2:0], q_bit} : mul_lo_nx;
      end
      if (state == FIX) begin
        // divide by zero reports the raw dividend and an all-ones quotient, unsigned
        io.hi_out <= is_div ? (dz ? a_raw : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
        io.lo_out <= is_div ? (dz ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
        io.div_zero <= dz;
      end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit
module tb_mdu_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  mdu_if #(.WIDTH(32)) io ();
  mdu_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  localparam logic [3:0] S_DIV = 4'b1000, S_DIVU = 4'b0100, S_MUL = 4'b0010, S_MULU = 4'b0001;

  task automatic set_starts(input logic [3:0] s);
    {io.div_start, io.divu_start, io.mul_start, io.mulu_start} = s;
  endtask

  // drive one request (at the next cycle, or right now if now=1) and wait for done
  task automatic do_op(input logic [3:0] s, input logic [31:0] aa, input logic [31:0] bb,
                       input bit now, output int n, output bit got);
    if (!now) @(posedge clk);
    #1;
    io.a = aa;
    io.b = bb;
    set_starts(s);
    #1;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0 && io.done) begin
        got = 1'b1;
        break;
      end
      if (io.busy) n++;
      @(posedge clk);
      #1;
      set_starts(4'b0);
      #1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL op_done_timeout: done not seen within 60 cycles"); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_starts(4'b0);
    io.a = '0;
    io.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", io.busy); end
    checks++; if (io.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", io.done); end
    checks++; if (io.hi_out !== 32'h0) begin errors++; $display("FAIL rst_hi: got %h want 0", io.hi_out); end
    checks++; if (io.lo_out !== 32'h0) begin errors++; $display("FAIL rst_lo: got %h want 0", io.lo_out); end
    checks++; if (io.div_zero !== 1'b0) begin errors++; $display("FAIL rst_dz: got %b want 0", io.div_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_mulu;
    int n; bit got;
    do_op(S_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n, got);
    checks++; if (n != 34) begin errors++; $display("FAIL mulu_busy_cycles: got %0d want 34", n); end
    checks++; if (io.hi_out !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_hi: got %h want fffffffe", io.hi_out); end
    checks++; if (io.lo_out !== 32'h00000001) begin errors++; $display("FAIL mulu_lo: got %h want 00000001", io.lo_out); end
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL mulu_busy_at_done: got %b want 0", io.busy); end
    @(posedge clk);
    #2;
    checks++; if (io.done !== 1'b0) begin errors++; $display("FAIL mulu_done_pulse: got %b want 0", io.done); end
  endtask

  task automatic test_mul;
    int n; bit got;
    do_op(S_MUL, 32'hFFFFFFFD, 32'd7, 1'b0, n, got);
    checks++; if (io.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_hi: got %h want ffffffff", io.hi_out); end
    checks++; if (io.lo_out !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_lo: got %h want ffffffeb", io.lo_out); end
  endtask

  task automatic test_div;
    int n; bit got;
    do_op(S_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n, got);
    checks++; if (io.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", io.lo_out); end
    checks++; if (io.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", io.hi_out); end
    do_op(S_DIVU, 32'd7, 32'd2, 1'b0, n, got);
    checks++; if (io.lo_out !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h want 3", io.lo_out); end
    checks++; if (io.hi_out !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 1", io.hi_out); end
    checks++; if (io.div_zero !== 1'b0) begin errors++; $display("FAIL divu_dz: got %b want 0", io.div_zero); end
  endtask

  task automatic test_div_zero;
    int n; bit got;
    do_op(S_DIVU, 32'h00001234, 32'd0, 1'b0, n, got);
    checks++; if (io.lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", io.lo_out); end
    checks++; if (io.hi_out !== 32'h00001234) begin errors++; $display("FAIL divu0_hi: got %h want 00001234", io.hi_out); end
    checks++; if (io.div_zero !== 1'b1) begin errors++; $display("FAIL divu0_dz: got %b want 1", io.div_zero); end
    do_op(S_DIV, 32'hFFFFFFFB, 32'd0, 1'b0, n, got);
    checks++; if (io.lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", io.lo_out); end
    checks++; if (io.hi_out !== 32'hFFFFFFFB) begin errors++; $display("FAIL div0_hi: got %h want fffffffb", io.hi_out); end
    checks++; if (io.div_zero !== 1'b1) begin errors++; $display("FAIL div0_dz: got %b want 1", io.div_zero); end
  endtask

  task automatic test_overflow;
    int n; bit got;
    do_op(S_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, got);
    checks++; if (io.lo_out !== 32'h80000000) begin errors++; $display("FAIL ovf_lo: got %h want 80000000", io.lo_out); end
    checks++; if (io.hi_out !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h want 0", io.hi_out); end
    checks++; if (io.div_zero !== 1'b0) begin errors++; $display("FAIL ovf_dz: got %b want 0", io.div_zero); end
  endtask

  // mul_start held 40 cycles with a divu pulse mid-operation: one op, one done
  task automatic test_held_start;
    int dones = 0;
    logic busy36 = 1'b1;
    @(posedge clk);
    #1;
    io.a = 32'd6;
    io.b = 32'd7;
    set_starts(S_MUL);
    for (int i = 0; i < 80; i++) begin
      if (i == 10) io.divu_start = 1'b1;
      if (i == 11) io.divu_start = 1'b0;
      if (i == 40) io.mul_start = 1'b0;
      #1;
      if (io.done) dones++;
      if (i == 36) busy36 = io.busy;
      @(posedge clk);
      #1;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL held_dones: got %0d want 1", dones); end
    checks++; if (busy36 !== 1'b0) begin errors++; $display("FAIL held_no_retrigger: busy got %b want 0", busy36); end
    checks++; if (io.lo_out !== 32'd42) begin errors++; $display("FAIL held_lo: got %h want 2a", io.lo_out); end
    checks++; if (io.hi_out !== 32'd0) begin errors++; $display("FAIL held_hi: got %h want 0", io.hi_out); end
  endtask

  task automatic test_simultaneous;
    int n; bit got;
    do_op(S_DIV | S_MUL, 32'd100, 32'd7, 1'b0, n, got);
    checks++; if (io.lo_out !== 32'd14) begin errors++; $display("FAIL simul_lo: got %h want e", io.lo_out); end
    checks++; if (io.hi_out !== 32'd2) begin errors++; $display("FAIL simul_hi: got %h want 2", io.hi_out); end
  endtask

  task automatic test_back_to_back;
    int n; bit got;
    do_op(S_MULU, 32'd9, 32'd9, 1'b0, n, got);
    do_op(S_DIVU, 32'd7, 32'd2, 1'b1, n, got);
    checks++; if (n != 34) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 34", n); end
    checks++; if (io.lo_out !== 32'd3) begin errors++; $display("FAIL b2b_lo: got %h want 3", io.lo_out); end
    checks++; if (io.hi_out !== 32'd1) begin errors++; $display("FAIL b2b_hi: got %h want 1", io.hi_out); end
  endtask

  task automatic test_reset_mid;
    int n; bit got;
    @(posedge clk);
    #1;
    io.a = 32'hFFFFFFFF;
    io.b = 32'd2;
    set_starts(S_MULU);
    repeat (11) begin
      @(posedge clk);
      #1;
      set_starts(4'b0);
    end
    checks++; if (io.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", io.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", io.busy); end
    checks++; if (io.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", io.done); end
    checks++; if (io.hi_out !== 32'h0) begin errors++; $display("FAIL mid_rst_hi: got %h want 0", io.hi_out); end
    checks++; if (io.lo_out !== 32'h0) begin errors++; $display("FAIL mid_rst_lo: got %h want 0", io.lo_out); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(S_MULU, 32'd3, 32'd5, 1'b0, n, got);
    checks++; if (n != 34) begin errors++; $display("FAIL post_rst_busy_cycles: got %0d want 34", n); end
    checks++; if (io.lo_out !== 32'd15) begin errors++; $display("FAIL post_rst_lo: got %h want f", io.lo_out); end
    checks++; if (io.hi_out !== 32'd0) begin errors++; $display("FAIL post_rst_hi: got %h want 0", io.hi_out); end
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_held_start();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
